// File: rtl/and_4_bit_arbiter.sv
// Round-robin arbiter sharing one 4-bit AND unit between four requesters.
// Each operation runs IDLE -> GRANT -> DONE and returns a one-cycle ack to the winner.

module and_4_bit (
  output logic [3:0] y,
  input  logic [3:0] a,
  input  logic [3:0] b
);

  assign y = a & b;

endmodule

module and_4_bit_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [3:0]  ack,
  output logic [3:0]  result,
  output logic [1:0]  grant_id,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0] state_q,    state_d;
  logic [1:0] ptr_q,      ptr_d;
  logic [3:0] op_a_q,     op_a_d;
  logic [3:0] op_b_q,     op_b_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [3:0] ack_q,      ack_d;
  logic [3:0] result_q,   result_d;

  logic [3:0] and_y;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

  and_4_bit u_and (
    .y (and_y),
    .a (op_a_q),
    .b (op_b_q)
  );

  // Search ptr, ptr+1, ... (mod 4); the first requester found wins.
  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    grant_id_d = grant_id_q;
    ack_d      = 4'b0000;
    result_d   = result_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          op_a_d     = a_in[{winner, 2'b00} +: 4];
          op_b_d     = b_in[{winner, 2'b00} +: 4];
          grant_id_d = winner;
          ptr_d      = winner + 2'd1;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        result_d = and_y;
        ack_d    = 4'b0001 << grant_id_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A reset mid-operation clears the latched operands too, so the in-flight
  // operation is dropped and never acknowledged.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      op_a_q     <= 4'd0;
      op_b_q     <= 4'd0;
      grant_id_q <= 2'd0;
      ack_q      <= 4'd0;
      result_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      result_q   <= result_d;
    end
  end

  assign ack      = ack_q;
  assign result   = result_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
